// File: rtl/axi_uartlite_if.sv
// -----------------------------------------------------------------------------
// axi_uartlite_if
// AXI4-Lite bus bundle for the UART-lite style responder.
//   Write address : axi_awvalid, axi_awready, axi_awaddr[31:0], axi_awprot[2:0]
//   Write data    : axi_wvalid, axi_wready, axi_wdata[31:0], axi_wstrb[3:0]
//   Write resp    : axi_bvalid, axi_bready, axi_bresp[1:0]
//   Read address  : axi_arvalid, axi_arready, axi_araddr[31:0], axi_arprot[2:0]
//   Read data     : axi_rvalid, axi_rready, axi_rdata[31:0], axi_rresp[1:0]
// Modports: master (bus initiator), slave (the responder).
// -----------------------------------------------------------------------------
interface axi_uartlite_if;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_awaddr;
  logic [2:0]  axi_awprot;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [1:0]  axi_bresp;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_araddr;
  logic [2:0]  axi_arprot;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;

  modport master (
    output axi_awvalid, axi_awaddr, axi_awprot,
    input  axi_awready,
    output axi_wvalid, axi_wdata, axi_wstrb,
    input  axi_wready,
    input  axi_bvalid, axi_bresp,
    output axi_bready,
    output axi_arvalid, axi_araddr, axi_arprot,
    input  axi_arready,
    input  axi_rvalid, axi_rdata, axi_rresp,
    output axi_rready
  );

  modport slave (
    input  axi_awvalid, axi_awaddr, axi_awprot,
    output axi_awready,
    input  axi_wvalid, axi_wdata, axi_wstrb,
    output axi_wready,
    output axi_bvalid, axi_bresp,
    input  axi_bready,
    input  axi_arvalid, axi_araddr, axi_arprot,
    output axi_arready,
    output axi_rvalid, axi_rdata, axi_rresp,
    input  axi_rready
  );
endinterface

// File: rtl/axi_uartlite_responder.sv
// -----------------------------------------------------------------------------
// axi_uartlite_responder
// AXI4-Lite register front end for a byte stream UART: an RX FIFO filled by
// rx_valid strobes and drained by reads of 0x0, a TX FIFO filled by writes to
// 0x4 and drained over the tx_valid/tx_ready handshake, a STAT register at 0x8
// (read clears the sticky overrun flag) and a CTRL register at 0xC (flushes).
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   bus                 AXI4-Lite slave modport (see axi_uartlite_if)
//   rx_valid, rx_data   one-cycle strobe carrying a received byte
//   tx_valid, tx_ready  byte-out handshake, tx_data is the TX FIFO head
// Parameter FIFO_DEPTH: entries per FIFO, power of two, at least 2.
// -----------------------------------------------------------------------------
module axi_uartlite_responder #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rstn,
  axi_uartlite_if.slave bus,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [7:0]    tx_data
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [1:0] SEL_RX   = 2'd0;
  localparam logic [1:0] SEL_TX   = 2'd1;
  localparam logic [1:0] SEL_STAT = 2'd2;
  localparam logic [1:0] SEL_CTRL = 2'd3;

  logic          run;
  logic          aw_held, w_held, bvalid_q, rvalid_q, overrun;
  logic [1:0]    aw_sel;
  logic [7:0]    w_byte;
  logic [31:0]   rdata_q, rd_word, stat;

  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wr, rx_rd;
  logic [CW-1:0] rx_cnt;
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr, tx_rd;
  logic [CW-1:0] tx_cnt;

  logic awready_c, wready_c, arready_c;
  logic aw_fire, w_fire, ar_fire, do_write;
  logic [1:0] wr_sel, rd_sel;
  logic [7:0] wr_byte;
  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_push, rx_pop, rx_drop, rx_flush, stat_rd;
  logic tx_push, tx_pop, tx_flush;
  logic unused_ok;

  // run stays low through reset so every ready is held low until the first
  // rising edge after rstn is released.
  assign awready_c = run & ~aw_held & ~bvalid_q;
  assign wready_c  = run & ~w_held & ~bvalid_q;
  assign arready_c = run & ~rvalid_q;

  assign aw_fire = bus.axi_awvalid & awready_c;
  assign w_fire  = bus.axi_wvalid & wready_c;
  assign ar_fire = bus.axi_arvalid & arready_c;

  // A write commits on the edge where address and data are both available,
  // whether each one was captured earlier or is handshaking right now.
  assign do_write = (aw_held | aw_fire) & (w_held | w_fire);
  assign wr_sel   = aw_held ? aw_sel : bus.axi_awaddr[3:2];
  assign wr_byte  = w_held ? w_byte : bus.axi_wdata[7:0];
  assign rd_sel   = bus.axi_araddr[3:2];

  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == FULL_CNT);

  assign stat = {26'b0, overrun, 1'b0, tx_full, tx_empty, rx_full, ~rx_empty};

  // A byte arriving on a full RX FIFO still fits when a read frees a slot on
  // the same edge; otherwise it is lost and recorded as an overrun.
  assign rx_pop   = ar_fire & (rd_sel == SEL_RX) & ~rx_empty;
  assign rx_push  = rx_valid & (~rx_full | rx_pop);
  assign rx_drop  = rx_valid & rx_full & ~rx_pop;
  assign rx_flush = do_write & (wr_sel == SEL_CTRL) & wr_byte[1];
  assign stat_rd  = ar_fire & (rd_sel == SEL_STAT);

  assign tx_push  = do_write & (wr_sel == SEL_TX) & ~tx_full;
  assign tx_pop   = ~tx_empty & tx_ready;
  assign tx_flush = do_write & (wr_sel == SEL_CTRL) & wr_byte[0];

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_mem[tx_rd];

  assign bus.axi_awready = awready_c;
  assign bus.axi_wready  = wready_c;
  assign bus.axi_arready = arready_c;
  assign bus.axi_bvalid  = bvalid_q;
  assign bus.axi_bresp   = 2'b00;
  assign bus.axi_rvalid  = rvalid_q;
  assign bus.axi_rdata   = rdata_q;
  assign bus.axi_rresp   = 2'b00;

  assign unused_ok = ^{bus.axi_awaddr[31:4], bus.axi_awaddr[1:0], bus.axi_awprot,
                       bus.axi_wdata[31:8], bus.axi_wstrb,
                       bus.axi_araddr[31:4], bus.axi_araddr[1:0], bus.axi_arprot};

  // Read data selected from the state as it stands before the AR edge.
  always_comb begin
    rd_word = '0;
    case (rd_sel)
      SEL_RX:   if (!rx_empty) rd_word = {24'b0, rx_mem[rx_rd]};
      SEL_STAT: rd_word = stat;
      default:  rd_word = '0;
    endcase
  end

  // Write channel: capture AW and W independently, respond once both are in.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run      <= 1'b0;
      aw_held  <= 1'b0;
      aw_sel   <= '0;
      w_held   <= 1'b0;
      w_byte   <= '0;
      bvalid_q <= 1'b0;
    end else begin
      run <= 1'b1;
      if (do_write) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
      end else begin
        if (aw_fire) begin
          aw_held <= 1'b1;
          aw_sel  <= bus.axi_awaddr[3:2];
        end
        if (w_fire) begin
          w_held <= 1'b1;
          w_byte <= bus.axi_wdata[7:0];
        end
        if (bvalid_q && bus.axi_bready) bvalid_q <= 1'b0;
      end
    end
  end

  // Read channel: one outstanding read, data held until rready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_fire) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_word;
    end else if (rvalid_q && bus.axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  // Sticky overrun: an RX flush always wins, a fresh overrun beats a STAT clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun <= 1'b0;
    end else if (rx_flush) begin
      overrun <= 1'b0;
    end else if (rx_drop) begin
      overrun <= 1'b1;
    end else if (stat_rd) begin
      overrun <= 1'b0;
    end
  end

  // RX FIFO pointers and occupancy; flush overrides push and pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else if (rx_flush) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push && !rx_flush) rx_mem[rx_wr] <= rx_data;
  end

  // TX FIFO pointers and occupancy; flush overrides push and pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else if (tx_flush) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push && !tx_flush) tx_mem[tx_wr] <= wr_byte;
  end
endmodule
